debug_dump_tx: RTL and testbench
================================

Name: debug_dump_tx

Overview:
- Reads the 32 architectural registers through the core's debug register view.
- Streams a framed snapshot of them out a single UART-style serial line (8N1, LSB first) for bench or board observation.
- Acts as the reader/consumer end of the register-file debug interface: the pipeline writes registers, this block reads and ships them.
- Sits beside the rv32 top; reg_raddr indexes the debug array, and reg_rdata is that array entry, read combinationally.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- NUM_REGS, 32, registers dumped per frame; address width fixed at 5.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request one dump frame; sampled only in IDLE
- reg_raddr  output  5  index of the register being read
- reg_rdata  input  32  debug value of register reg_raddr, combinational
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset is asynchronous and active-high. While rst=1, and immediately on its assertion: tx=1, busy=0, done=0, reg_raddr=0, state=IDLE, all counters 0, checksum 0.
- Frame is 130 bytes:
  - byte 0 = sync 0xA5
  - bytes 1..128 = registers 0..31, each 4 bytes little-endian
  - byte 129 = XOR of bytes 1..128 (sync excluded)
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If start=1 at the edge, go to LOAD, set busy=1, clear the byte index and checksum.
  - LOAD (1 cycle, tx=1): select the next byte into the shift register.
    - Byte 0 is 0xA5.
    - For bytes 1..128, when byte-in-word = 0, capture reg_rdata into a 32-bit word snapshot; all 4 bytes of the word come from this snapshot.
    - Byte 129 is the checksum.
    - Fold data bytes into the checksum here. Then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits, CLKS_PER_BIT cycles each, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If the byte index is below 129, increment it and go to LOAD.
    - Otherwise go to IDLE, with busy=0 and done=1 for that first IDLE cycle.
- reg_raddr is registered.
  - It holds the word index during every LOAD that captures a word.
  - It increments after the 4th byte of each register.
  - It returns to 0 when the frame ends.
- Timing: if start is sampled at the edge closing cycle N, frame cycles are N+1 .. N+130*(10*CLKS_PER_BIT+1), and done is high in the following cycle.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is accepted, giving back-to-back frames.
- Reset mid-frame aborts with no partial completion: no done pulse, and the next frame restarts at 0xA5.
- The baud counter wraps to 0 at CLKS_PER_BIT-1.
- The bit counter covers 0..7 and the byte index 0..129; no overflow is possible.

Decomposition:
- Shared package dbg_pkg holds:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES = 130
  - the state enum (IDLE, LOAD, START, DATA, STOP)
- Sub-module uart_tx_byte implements the START/DATA/STOP serializer with the baud counter.
  - Handshake: load/data_in/ready.
  - debug_dump_tx keeps frame sequencing, register addressing, snapshot and checksum.

Test Plan:
- Reset release, CLKS_PER_BIT=4, start held 0 for 100 cycles -> tx=1, busy=0, done=0, reg_raddr=0 throughout.
- reg[i]=i for all i, one start pulse -> decoded bytes A5, 00 00 00 00, 01 00 00 00, ... 1F 00 00 00, checksum 00; done exactly 5331 cycles after the start cycle; busy low in the done cycle.
- reg1=0xDEADBEEF, others 0 -> bytes 5..8 = EF BE AD DE, checksum 0x22, all other data bytes 00.
- reg_rdata for reg 3 changed from 0x11223344 to 0xFFFFFFFF one cycle after its word LOAD -> transmitted bytes 44 33 22 11 (snapshot); start pulses while busy produce no second frame.
- rst asserted during byte 10 -> tx=1 and busy=0 in the same cycle; new start yields a full frame beginning 0xA5 with correct checksum.
- start asserted in the done cycle -> second frame's LOAD begins the next cycle; two complete, identical frames with no idle gap.

Source files
------------

// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dbg_pkg
//  Description : Shared constants and state encoding for the register-file
//                debug dump transmitter and its byte serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbg_pkg;

    // First byte of every frame, lets a receiver find frame alignment.
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    // Sync + 32 registers x 4 bytes + checksum.
    localparam int         FRAME_BYTES = 130;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

endpackage : dbg_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serializer, LSB first. Each bit is held for
//                CLKS_PER_BIT cycles.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   system clock, rising edge
//    rst      in   asynchronous active-high reset
//    load     in   accept data_in (honoured only while the line is idle)
//    data_in  in   byte to transmit
//    ready    out  serializer idle, or in the final cycle of a stop bit
//    tx       out  serial line, idle high
// ============================================================================
module uart_tx_byte
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       tx
);

    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                w_baud_last;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (load) w_next = START;
            START:   if (w_baud_last) w_next = DATA;
            DATA:    if (w_baud_last && (r_bit == 3'd7)) w_next = STOP;
            STOP:    if (w_baud_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (r_state == IDLE) begin
            r_baud <= '0;
            r_bit  <= '0;
            if (load) begin
                r_shift <= data_in;
            end
        end else begin
            r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
            if ((r_state == DATA) && w_baud_last) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

    // Signalling ready in the last stop cycle lets the next LOAD follow the
    // stop bit directly, so a byte slot is exactly 10*CLKS_PER_BIT+1 cycles.
    assign ready = (r_state == IDLE) || ((r_state == STOP) && w_baud_last);

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx
//  Description : Reads the architectural registers through the debug
//                register view and streams a framed snapshot over an 8N1
//                serial line: A5, 32 words little-endian, XOR checksum.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-high reset
//    start      in   request one dump frame (sampled only when idle)
//    reg_raddr  out  register index presented to the debug view
//    reg_rdata  in   combinational debug value of register reg_raddr
//    tx         out  serial line, idle high
//    busy       out  frame in progress
//    done       out  one-cycle pulse at frame completion
// ============================================================================
module debug_dump_tx
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_raddr,
    input  logic [31:0] reg_rdata,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] c_DATA_LAST = 8'(4 * NUM_REGS);
    localparam logic [7:0] c_LAST_BYTE = 8'(FRAME_BYTES - 1);

    // The frame sequencer uses IDLE and LOAD itself; START stands for "a byte
    // is on the line" while the serializer walks its own START/DATA/STOP.
    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_byte_idx;
    logic [7:0]  r_csum;
    logic [31:0] r_word;
    logic [4:0]  r_raddr;
    logic        r_busy;
    logic        r_done;

    logic [1:0]  w_bsel;
    logic        w_is_data;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic        w_load;
    logic        w_ready;

    // Byte-in-word for data byte k (k = 1..128) is (k-1) mod 4.
    assign w_bsel      = r_byte_idx[1:0] - 2'd1;
    assign w_is_data   = (r_byte_idx != 8'd0) && (r_byte_idx <= c_DATA_LAST);
    assign w_last_byte = (r_byte_idx == c_LAST_BYTE);
    assign w_load      = (r_state == LOAD);

    // Byte 0 of a word comes straight from the debug view (same value that is
    // being snapshotted); bytes 1..3 come from the snapshot so that a register
    // changing mid-word cannot tear the transmitted value.
    assign w_word = (w_bsel == 2'd0) ? reg_rdata : r_word;

    always_comb begin
        w_byte = SYNC_BYTE;
        if (w_is_data) begin
            w_byte = w_word[{w_bsel, 3'b000} +: 8];
        end else if (w_last_byte) begin
            w_byte = r_csum;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .data_in (w_byte),
        .ready   (w_ready),
        .tx      (tx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = START;
            START:   if (w_ready) w_next = w_last_byte ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_word     <= '0;
            r_raddr    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                    end
                end
                LOAD: begin
                    if (w_is_data) begin
                        r_csum <= r_csum ^ w_byte;
                        if (w_bsel == 2'd0) begin
                            r_word <= reg_rdata;
                        end
                    end
                end
                START: begin
                    if (w_ready) begin
                        if (w_last_byte) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_raddr <= '0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 8'd1;
                            if (w_is_data && (w_bsel == 2'd3)) begin
                                r_raddr <= r_raddr + 5'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_raddr = r_raddr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : debug_dump_tx
`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_tx
//  Description : Directed self-checking bench for debug_dump_tx. A register
//                model feeds the debug view, a UART decoder collects bytes,
//                and a scoreboard queue holds the expected frame bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_dump_tx;

    localparam int C         = 4;
    localparam int FRAME     = 130;
    localparam int FRAME_CYC = 130 * (10 * C + 1) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic        ovr;

    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];
    int          n_chk    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          stop_err = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    assign reg_rdata = (ovr && (reg_raddr == 5'd3)) ? 32'hFFFF_FFFF : regs[reg_raddr];

    debug_dump_tx #(
        .CLKS_PER_BIT (C),
        .NUM_REGS     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

`define CHK(TAG, OBS, EXP) \
    begin \
        n_chk++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
        end \
    end

    // Serial decoder: finds a start bit, samples each bit near its middle.
    initial begin
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                if (tx !== 1'b1) stop_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_frame();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 4; k++) begin
                b = regs[r][8*k +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic do_start(output int ps);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ps = cyc;
    endtask

    task automatic wait_done(output int dcyc, output logic dbusy);
        int k;
        k     = 0;
        dcyc  = -1;
        dbusy = 1'bx;
        while (k < FRAME_CYC + 100) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                dcyc  = cyc;
                dbusy = busy;
                break;
            end
        end
        `CHK("done_seen", (dcyc >= 0), 1'b1)
    endtask

    task automatic check_rx(input int n, input string tag);
        int k;
        logic [7:0] got;
        logic [7:0] want;
        k = 0;
        repeat (2) @(negedge clk);
        while ((rx_q.size() < n) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        `CHK($sformatf("%s_rx_count", tag), rx_q.size(), n)
        for (int i = 0; i < n; i++) begin
            if ((rx_q.size() > 0) && (exp_q.size() > 0)) begin
                got  = rx_q.pop_front();
                want = exp_q.pop_front();
                `CHK($sformatf("%s_byte%0d", tag, i), got, want)
            end
        end
        `CHK($sformatf("%s_stop_bits", tag), stop_err, 0)
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   ps;
        int   dc;
        int   dc2;
        int   d0;
        int   k;
        logic db;

        rst   = 1'b1;
        start = 1'b0;
        ovr   = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        repeat (2) @(negedge clk);
        `CHK("reset_state", {tx, busy, done, reg_raddr}, {1'b1, 1'b0, 1'b0, 5'd0})
        rst = 1'b0;

        // Idle with start held low.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            `CHK("idle_hold", {tx, busy, done, reg_raddr}, {1'b1, 1'b0, 1'b0, 5'd0})
        end

        // Ramp pattern: reg[i] = i.
        push_frame();
        d0 = done_cnt;
        do_start(ps);
        wait_done(dc, db);
        `CHK("ramp_latency", dc - ps + 1, FRAME_CYC)
        `CHK("ramp_busy_in_done", db, 1'b0)
        check_rx(FRAME, "ramp");
        `CHK("ramp_done_count", done_cnt, d0 + 1)
        `CHK("ramp_raddr_end", reg_raddr, 5'd0)

        // Single non-zero register.
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'hDEAD_BEEF;
        push_frame();
        do_start(ps);
        wait_done(dc, db);
        check_rx(FRAME, "beef");

        // Snapshot: reg 3 changes one cycle after its word is loaded; extra
        // start pulses while busy must not queue a frame.
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A00_0000;
        regs[3] = 32'h1122_3344;
        push_frame();
        d0 = done_cnt;
        do_start(ps);
        k = 0;
        while ((reg_raddr !== 5'd3) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        `CHK("snap_raddr_w3", reg_raddr, 5'd3)
        @(negedge clk);
        ovr = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(dc, db);
        repeat (400) @(negedge clk);
        `CHK("snap_busy_after", busy, 1'b0)
        `CHK("snap_done_count", done_cnt, d0 + 1)
        check_rx(FRAME, "snap");
        ovr = 1'b0;

        // Reset during byte 10 (inside its start bit).
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        d0 = done_cnt;
        do_start(ps);
        repeat (412) @(posedge clk);
        #1;
        `CHK("abort_tx_low_before", tx, 1'b0)
        rst = 1'b1;
        #1;
        `CHK("abort_tx", tx, 1'b1)
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_done", done, 1'b0)
        `CHK("abort_raddr", reg_raddr, 5'd0)
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        `CHK("abort_no_done", done_cnt, d0)
        rx_q.delete();
        exp_q.delete();
        stop_err = 0;
        push_frame();
        do_start(ps);
        wait_done(dc, db);
        `CHK("abort_next_latency", dc - ps + 1, FRAME_CYC)
        check_rx(FRAME, "after_rst");

        // Back-to-back frames: start in the done cycle.
        push_frame();
        push_frame();
        do_start(ps);
        wait_done(dc, db);
        `CHK("b2b_first_latency", dc - ps + 1, FRAME_CYC)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        `CHK("b2b_busy_next", busy, 1'b1)
        `CHK("b2b_tx_load", tx, 1'b1)
        wait_done(dc2, db);
        `CHK("b2b_second_latency", dc2 - dc, FRAME_CYC)
        check_rx(2 * FRAME, "b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

`undef CHK

endmodule : tb_debug_dump_tx
`default_nettype wire
